// File: rtl/axi_lite_master_bridge_if.sv
// AXI4-Lite channel bundle (AW, W, B, AR, R) between the bridge and a register slave.
// Master drives valids, payloads and b/r readies; the slave drives the rest.
interface axi_lite_master_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [2:0]                aw_prot;
    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;
    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;
    logic [2:0]                ar_prot;
    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_prot, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_prot, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding cmd -> AXI4-Lite write/read bridge; 3 cycles accept->rsp with a zero-wait slave.
// cmd_ready only in IDLE, response held until rsp_ready; AXI_LITE_MASTER_TIMEOUT_EN adds a response watchdog.
module axi_lite_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_we,
    axi_lite_master_bridge_if.master axi
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRESP,
        RADDR,
        RDATA,
        RSP
    } state_e;

    state_e                    state_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic                      we_q;
    logic                      aw_valid_q;
    logic                      w_valid_q;
    logic                      aw_done_q;
    logic                      w_done_q;
    logic                      b_ready_q;
    logic                      ar_valid_q;
    logic                      r_ready_q;
    logic                      rsp_valid_q;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;
    logic [1:0]                rsp_resp_q;

    logic aw_done_d;
    logic w_done_d;
    logic busy;
    logic tmo_hit;

    assign busy      = (state_q == WRITE) || (state_q == WRESP) ||
                       (state_q == RADDR) || (state_q == RDATA);
    assign aw_done_d = aw_done_q | (aw_valid_q & axi.aw_ready);
    assign w_done_d  = w_done_q  | (w_valid_q  & axi.w_ready);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = busy && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (state_q == IDLE && cmd_valid) begin
            tmo_q <= '0;
        end else if (busy) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0) & busy;
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            we_q        <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else if (tmo_hit) begin
            // Watchdog abort: withdraw everything; late b/r beats land on deasserted readies.
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b10;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        we_q    <= cmd_we;
                        if (cmd_we) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= WRITE;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= RADDR;
                        end
                    end
                end
                WRITE: begin
                    if (aw_valid_q && axi.aw_ready) aw_valid_q <= 1'b0;
                    if (w_valid_q && axi.w_ready)   w_valid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        b_ready_q <= 1'b1;
                        state_q   <= WRESP;
                    end else begin
                        aw_done_q <= aw_done_d;
                        w_done_q  <= w_done_d;
                    end
                end
                WRESP: begin
                    if (axi.b_valid) begin
                        b_ready_q   <= 1'b0;
                        rsp_resp_q  <= axi.b_resp;
                        rsp_rdata_q <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RADDR: begin
                    if (axi.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= RDATA;
                    end
                end
                RDATA: begin
                    if (axi.r_valid) begin
                        r_ready_q   <= 1'b0;
                        rsp_rdata_q <= axi.r_data;
                        rsp_resp_q  <= axi.r_resp;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready    = (state_q == IDLE) && !rst_i;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_resp     = rsp_resp_q;
    assign rsp_we       = we_q;

    assign axi.aw_valid = aw_valid_q;
    assign axi.aw_addr  = addr_q;
    assign axi.aw_prot  = 3'b000;
    assign axi.w_valid  = w_valid_q;
    assign axi.w_data   = wdata_q;
    assign axi.w_strb   = wstrb_q;
    assign axi.b_ready  = b_ready_q;
    assign axi.ar_valid = ar_valid_q;
    assign axi.ar_addr  = addr_q;
    assign axi.ar_prot  = 3'b000;
    assign axi.r_ready  = r_ready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: delay-programmable register slave plus a flat memory reference model.
module tb_axi_lite_master_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int n_chk = 0;
    int n_fail = 0;

    axi_lite_master_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ifc ();

    axi_lite_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_we(rsp_we), .axi(ifc)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- register slave ----------------
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit ar_stall = 1'b0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit got_aw, got_w, b_pend, r_pend;
    logic [3:0]  s_awaddr, s_araddr, last_araddr;
    logic [31:0] s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [31:0] smem [16];
    int b_hs_n, rsp_hs_n;

    logic        aw_hs, w_hs;
    logic [3:0]  cur_awaddr, cur_wstrb;
    logic [31:0] cur_wdata, wmask;

    assign ifc.aw_ready = ifc.aw_valid && !got_aw && (aw_cnt >= aw_dly);
    assign ifc.w_ready  = ifc.w_valid && !got_w && (w_cnt >= w_dly);
    assign ifc.b_valid  = b_pend && (b_cnt >= b_dly);
    assign ifc.b_resp   = (s_awaddr == 4'd15) ? 2'b10 : 2'b00;
    assign ifc.ar_ready = ifc.ar_valid && !ar_stall && !r_pend && (ar_cnt >= ar_dly);
    assign ifc.r_valid  = r_pend && (r_cnt >= r_dly);
    assign ifc.r_data   = s_rdata;
    assign ifc.r_resp   = (s_araddr == 4'd15) ? 2'b10 : 2'b00;

    assign aw_hs      = ifc.aw_valid && ifc.aw_ready;
    assign w_hs       = ifc.w_valid && ifc.w_ready;
    assign cur_awaddr = aw_hs ? ifc.aw_addr : s_awaddr;
    assign cur_wdata  = w_hs ? ifc.w_data : s_wdata;
    assign cur_wstrb  = w_hs ? ifc.w_strb : s_wstrb;
    assign wmask      = {{8{cur_wstrb[3]}}, {8{cur_wstrb[2]}}, {8{cur_wstrb[1]}}, {8{cur_wstrb[0]}}};

    always @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) smem[i] <= '0;
            got_aw <= 0; got_w <= 0; b_pend <= 0; r_pend <= 0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            s_awaddr <= '0; s_araddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_rdata <= '0;
        end else begin
            aw_cnt <= (ifc.aw_valid && !aw_hs && !got_aw) ? aw_cnt + 1 : 0;
            w_cnt  <= (ifc.w_valid && !w_hs && !got_w) ? w_cnt + 1 : 0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                smem[cur_awaddr] <= (smem[cur_awaddr] & ~wmask) | (cur_wdata & wmask);
                s_awaddr <= cur_awaddr;
                got_aw <= 0; got_w <= 0;
                b_pend <= 1; b_cnt <= 0;
            end else begin
                if (aw_hs) begin got_aw <= 1; s_awaddr <= ifc.aw_addr; end
                if (w_hs)  begin got_w <= 1; s_wdata <= ifc.w_data; s_wstrb <= ifc.w_strb; end
            end
            if (b_pend) begin
                if (ifc.b_valid && ifc.b_ready) begin b_pend <= 0; b_hs_n <= b_hs_n + 1; end
                else b_cnt <= b_cnt + 1;
            end
            if (r_pend) begin
                if (ifc.r_valid && ifc.r_ready) r_pend <= 0;
                else r_cnt <= r_cnt + 1;
                ar_cnt <= 0;
            end else if (ifc.ar_valid && ifc.ar_ready) begin
                r_pend <= 1; r_cnt <= 0; ar_cnt <= 0;
                s_araddr <= ifc.ar_addr; last_araddr <= ifc.ar_addr;
                s_rdata <= smem[ifc.ar_addr];
            end else begin
                ar_cnt <= ifc.ar_valid ? ar_cnt + 1 : 0;
            end
        end
        if (rsp_valid && rsp_ready) rsp_hs_n <= rsp_hs_n + 1;
    end

    // ---------------- reference model + checks ----------------
    logic [31:0] ref_mem [16];
    int exp_rsp_n = 0;
    int exp_b_n = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // mode: 0 plain, 1 zero-wait timing, 2 staggered AW/W, 3 watchdog expiry
    task automatic do_cmd(input bit we, input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold, input int mode, input bit exp_tmo);
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int lat, arv, guard;
        if (exp_tmo) begin
            exp_resp = 2'b10; exp_rdata = '0;
        end else if (we) begin
            exp_resp = (addr == 4'd15) ? 2'b10 : 2'b00; exp_rdata = '0;
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
            exp_b_n++;
        end else begin
            exp_resp = (addr == 4'd15) ? 2'b10 : 2'b00; exp_rdata = ref_mem[addr];
        end
        @(negedge clk_i);
        cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        guard = 0;
        while (!cmd_ready && guard < 50) begin @(negedge clk_i); guard++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        @(posedge clk_i); #1 cmd_valid = 0;
        lat = 0; arv = 0;
        while (1) begin
            @(negedge clk_i); lat++;
            if (ifc.ar_valid) arv++;
            if (mode == 1 && lat == 1) begin
                chk("aw_w_rise", {ifc.aw_valid, ifc.w_valid}, we ? 2'b11 : 2'b00);
                chk("ar_rise", ifc.ar_valid, !we);
            end
            if (mode == 2 && lat == 2) begin
                chk("aw_dropped", ifc.aw_valid, 0);
                chk("w_held", ifc.w_valid, 1);
            end
            if (rsp_valid || lat >= 300) break;
        end
        chk("rsp_arrived", rsp_valid, 1);
        if (mode == 1) chk("latency", lat, 3);
        if (mode == 3) chk("ar_valid_cycles", arv, 8);
        chk("rsp_we", rsp_we, we);
        chk("rsp_resp", rsp_resp, exp_resp);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1; cmd_we = 0;
            @(negedge clk_i);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_payload", {rsp_we, rsp_resp, rsp_rdata}, {we, exp_resp, exp_rdata});
            chk("hold_cmd_ready", {cmd_ready, ifc.ar_valid, ifc.aw_valid}, 3'b000);
        end
        cmd_valid = 0; rsp_ready = 1;
        @(posedge clk_i); #1 rsp_ready = 0;
        exp_rsp_n++;
        @(negedge clk_i);
        chk("b2b_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    endtask

    initial begin
        int guard;
        bit seen;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        b_hs_n = 0; rsp_hs_n = 0;
        rst_i = 1; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {ifc.aw_valid, ifc.w_valid, ifc.ar_valid, ifc.b_ready, ifc.r_ready, rsp_valid}, 6'd0);
        rst_i = 0;
        @(negedge clk_i);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_payload", {rsp_we, rsp_resp, rsp_rdata}, 35'd0);
        chk("prot", {ifc.aw_prot, ifc.ar_prot}, 6'd0);

        do_cmd(1, 4'd2, 32'hDEADBEEF, 4'hF, 0, 1, 0);
        do_cmd(0, 4'd2, 32'h0, 4'h0, 0, 1, 0);
        chk("ar_addr", last_araddr, 4'd2);

        aw_dly = 0; w_dly = 4;
        do_cmd(1, 4'd5, 32'hA5A5_1234, 4'hA, 0, 2, 0);
        w_dly = 0;
        do_cmd(0, 4'd5, 32'h0, 4'h0, 5, 0, 0);
        do_cmd(1, 4'd2, 32'h1234_5678, 4'h0, 0, 0, 0);
        do_cmd(0, 4'd2, 32'h0, 4'h0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly = $urandom_range(0, 3);
            do_cmd($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 2), 0, 0);
        end
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0;

        // reset while waiting for read data
        r_dly = 20;
        @(negedge clk_i);
        cmd_valid = 1; cmd_we = 0; cmd_addr = 4'd3;
        @(posedge clk_i); #1 cmd_valid = 0;
        guard = 0;
        while (!ifc.r_ready && guard < 20) begin @(negedge clk_i); guard++; end
        chk("reach_rdata", ifc.r_ready, 1);
        rst_i = 1;
        #1 chk("mid_rst_cmd_ready", cmd_ready, 0);
        @(posedge clk_i); #1 rst_i = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        @(negedge clk_i);
        chk("abort_valids", {ifc.aw_valid, ifc.w_valid, ifc.ar_valid, ifc.b_ready, ifc.r_ready, rsp_valid}, 6'd0);
        chk("abort_idle", cmd_ready, 1);
        r_dly = 0;
        seen = 0;
        repeat (25) begin @(negedge clk_i); if (rsp_valid) seen = 1; end
        chk("abort_no_rsp", seen, 0);
        do_cmd(1, 4'd7, 32'hCAFE_F00D, 4'hC, 0, 0, 0);
        do_cmd(0, 4'd7, 32'h0, 4'h0, 1, 1, 0);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        ar_stall = 1;
        do_cmd(0, 4'd7, 32'h0, 4'h0, 0, 3, 1);
        ar_stall = 0;
        do_cmd(0, 4'd7, 32'h0, 4'h0, 0, 0, 0);
`endif

        repeat (3) @(negedge clk_i);
        chk("rsp_count", rsp_hs_n, exp_rsp_n);
        chk("b_count", b_hs_n, exp_b_n);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
